delay_fifo_ctrl: RTL and testbench
==================================

# delay_fifo_ctrl

Sequencer for the 32-bit delay-alignment FIFO used to align the x0/x0z sample streams with trigger-path latency. Drives the FIFO's write/read enables from a run-time programmable delay, tracks FIFO occupancy, and issues a registered data-valid flag to downstream trigger logic. Supports start, steady streaming and an orderly drain on stop, replacing free-running, reset-released enable generation.

## Interface
- DEPTH, 1024: FIFO depth in words.
- CNT_W, 13: width of delay/level counters; must hold DEPTH.
- DELAY_DEFAULT, 73: delay in cycles loaded at reset.
- clk  in  1  system clock; the FIFO shares this clock.
- rst  in  1  reset; asynchronous, active-high; also drives the FIFO reset.
- en  in  1  run request; level-sensitive.
- cfg_we  in  1  delay write strobe.
- cfg_delay  in  CNT_W  new delay value.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- wr_en  out  1  FIFO write enable; registered.
- rd_en  out  1  FIFO read enable; registered.
- data_valid  out  1  FIFO dout valid; equals rd_en delayed 1 cycle.
- level  out  CNT_W  tracked FIFO occupancy.
- state  out  2  state: 0 IDLE, 1 FILL, 2 STREAM, 3 FLUSH.
- err_ovf  out  1  sticky: write attempted while fifo_full.
- err_udf  out  1  sticky: read attempted while fifo_empty.

## Operation
- Reset values:
  - All outputs are 0, and state is IDLE.
  - delay_reg = DELAY_DEFAULT.
  - fill_cnt = 0.
- Delay programming:
  - cfg_we is accepted only in IDLE. Otherwise it is ignored and delay_reg is unchanged.
  - The written value is clamped to the range 1..DEPTH-1.
- IDLE:
  - wr_en = 0, rd_en = 0, fill_cnt = 0.
  - en = 1 → FILL.
- FILL:
  - wr_en = 1, rd_en = 0.
  - fill_cnt increments once per cycle while in FILL.
  - fill_cnt == delay_reg-1 and en = 1 → STREAM.
  - en = 0 → FLUSH.
- STREAM:
  - wr_en = 1, rd_en = 1.
  - en = 0 → FLUSH.
- FLUSH:
  - wr_en = 0.
  - rd_en_next = (level_next != 0).
  - level_next == 0 → IDLE.
  - en is ignored until IDLE is reached.
- Level tracking:
  - level_next = level + (wr_en & ~fifo_full) − (rd_en & ~fifo_empty).
  - Simultaneous accepted write and read leave level unchanged.
  - level is saturated to 0..DEPTH.
- Boundary conditions:
  - Full/empty are never reached in normal operation, because delay < DEPTH and reads start before the FIFO fills.
  - If wr_en & fifo_full occurs, the write is dropped by the FIFO and the controller continues.
  - If rd_en & fifo_empty occurs, level holds at 0.
- Reset mid-operation: immediately returns to IDLE with all outputs 0. The programmed delay_reg is reset to DELAY_DEFAULT.

## Timing
- Start latency: en sampled high at edge N (in IDLE) → state = FILL and wr_en = 1 after edge N+1.
- First read: rd_en = 1 after edge N+1+delay_reg, so the first read occurs exactly delay_reg cycles after the first write.
- data_valid:
  - Asserts one cycle after rd_en, matching the FIFO's 1-cycle read latency.
  - Total input-to-valid-output latency is delay_reg+1 cycles.
- Stop latency: en sampled low at edge M → wr_en = 0 after edge M+1.
- Drain: rd_en stays high exactly `level` more cycles, then the controller returns to IDLE.
- No combinational path from any input to any output.

## Configuration
- DELAY_FIFO_CTRL_ERR_EN:
  - Defined: err_ovf and err_udf are sticky, set on the offending cycle, and cleared only by rst.
  - Undefined: both outputs are tied 0 and the detection logic is omitted.

## Test plan
- Default start: release reset, en = 1 held → rd_en first high exactly 73 cycles after wr_en first high; data_valid one cycle later; level settles at 73.
- Programmed delay: in IDLE, cfg_delay = 5, cfg_we = 1, then en = 1 → rd_en rises 5 cycles after wr_en; level steady at 5.
- Clamping: cfg_delay = 0 → effective delay 1; cfg_delay = 2000 with DEPTH = 1024 → effective delay 1023.
- Config rejection and drain: cfg_we pulsed in STREAM (rejected, delay unchanged), then en = 0 → wr_en drops next cycle, rd_en stays high 73 cycles, state returns to IDLE with level = 0.
- Mid-operation reset: assert rst during FILL at fill_cnt = 30 → all outputs 0 asynchronously; state IDLE; next start uses delay 73.
- Error flags (macro defined): force fifo_empty = 1 during STREAM → err_udf = 1 and stays set until rst. Macro undefined → err_udf remains 0.

Source files
------------

// File: rtl/delay_fifo_ctrl.sv
// delay_fifo_ctrl: enable sequencer for the x0/x0z delay-alignment FIFO.
// Ports: clk/rst (async, high), en_i run request, cfg_we_i/cfg_delay_i
//   delay programming, fifo_full_i/fifo_empty_i flags; wr_en_o/rd_en_o
//   FIFO enables, data_valid_o, level_o, state_o, err_ovf_o/err_udf_o.
// Optional: define DELAY_FIFO_CTRL_ERR_EN for sticky error flags.
module delay_fifo_ctrl #(
    parameter int DEPTH         = 1024,
    parameter int CNT_W         = 13,
    parameter int DELAY_DEFAULT = 73
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             cfg_we_i,
    input  logic [CNT_W-1:0] cfg_delay_i,
    input  logic             fifo_full_i,
    input  logic             fifo_empty_i,
    output logic             wr_en_o,
    output logic             rd_en_o,
    output logic             data_valid_o,
    output logic [CNT_W-1:0] level_o,
    output logic [1:0]       state_o,
    output logic             err_ovf_o,
    output logic             err_udf_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] LVL_MAX = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] DLY_MAX = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DLY_RST = CNT_W'(DELAY_DEFAULT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_e           state_q, state_d;
    logic             en_q;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;
    logic             dv_q;
    logic             wr_acc;
    logic             rd_acc;

    // Only enables the FIFO will actually honour move the level.
    assign wr_acc = wr_q & ~fifo_full_i;
    assign rd_acc = rd_q & ~fifo_empty_i;

    always_comb begin
        level_d = level_q;
        if (wr_acc && !rd_acc && level_q < LVL_MAX) begin
            level_d = level_q + ONE;
        end else if (rd_acc && !wr_acc && level_q != '0) begin
            level_d = level_q - ONE;
        end
    end

    always_comb begin
        delay_d = delay_q;
        if (state_q == IDLE && cfg_we_i) begin
            if (cfg_delay_i == '0) begin
                delay_d = ONE;
            end else if (cfg_delay_i > DLY_MAX) begin
                delay_d = DLY_MAX;
            end else begin
                delay_d = cfg_delay_i;
            end
        end
    end

    // en is registered first, so every output is a pure flop.
    always_comb begin
        state_d = state_q;
        fill_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (en_q) state_d = FILL;
            end
            FILL: begin
                fill_d = fill_q + ONE;
                if (!en_q) begin
                    state_d = FLUSH;
                end else if (fill_q == delay_q - ONE) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (!en_q) state_d = FLUSH;
            end
            FLUSH: begin
                if (level_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        wr_d = (state_d == FILL) || (state_d == STREAM);
        // Drain reads continue only while words remain after this edge.
        rd_d = (state_d == STREAM) ||
               (state_d == FLUSH && level_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            delay_q <= DLY_RST;
            fill_q  <= '0;
            level_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_i;
            delay_q <= delay_d;
            fill_q  <= fill_d;
            level_q <= level_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            dv_q    <= rd_q;
        end
    end

`ifdef DELAY_FIFO_CTRL_ERR_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (wr_q & fifo_full_i);
            udf_q <= udf_q | (rd_q & fifo_empty_i);
        end
    end

    assign err_ovf_o = ovf_q;
    assign err_udf_o = udf_q;
`else
    assign err_ovf_o = 1'b0;
    assign err_udf_o = 1'b0;
`endif

    assign wr_en_o      = wr_q;
    assign rd_en_o      = rd_q;
    assign data_valid_o = dv_q;
    assign level_o      = level_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_delay_fifo_ctrl.sv
// tb_delay_fifo_ctrl: bench for delay_fifo_ctrl.
// Latency scoreboard on data_valid plus directed start/drain/error cases.
module tb_delay_fifo_ctrl;

    localparam int CNT_W = 13;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             cfg_we;
    logic [CNT_W-1:0] cfg_delay;
    logic             fifo_full;
    logic             fifo_empty;
    logic             wr_en;
    logic             rd_en;
    logic             dv;
    logic [CNT_W-1:0] level;
    logic [1:0]       state;
    logic             err_ovf;
    logic             err_udf;

    int n_run  = 0;
    int n_fail = 0;
    int cyc;
    int exp_delay;
    int exp_err;
    bit sb_on;
    int sb_q[$];

    always #5 clk = ~clk;

    delay_fifo_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en),
        .cfg_we_i     (cfg_we),
        .cfg_delay_i  (cfg_delay),
        .fifo_full_i  (fifo_full),
        .fifo_empty_i (fifo_empty),
        .wr_en_o      (wr_en),
        .rd_en_o      (rd_en),
        .data_valid_o (dv),
        .level_o      (level),
        .state_o      (state),
        .err_ovf_o    (err_ovf),
        .err_udf_o    (err_udf)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Each accepted write must come out as data_valid delay+1 cycles later.
    initial begin
        int e;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb_on && !rst) begin
                if (wr_en && !fifo_full) begin
                    sb_q.push_back(cyc + exp_delay + 1);
                end
                if (dv) begin
                    if (sb_q.size() == 0) begin
                        chk("dv_unexpected", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("dv_latency", cyc, e);
                    end
                end
            end
        end
    end

    task automatic set_delay(input int d);
        cfg_delay = CNT_W'(d);
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic start_run(input string tag, input int d);
        int n;
        exp_delay = d;
        en = 1'b1;
        tick();
        chk({tag, "_st_n"}, int'(state), 0);
        chk({tag, "_wr_n"}, int'(wr_en), 0);
        tick();
        chk({tag, "_st_fill"}, int'(state), 1);
        chk({tag, "_wr_on"}, int'(wr_en), 1);
        chk({tag, "_rd_off"}, int'(rd_en), 0);
        n = 0;
        while (!rd_en && n < 2100) begin
            tick();
            n++;
        end
        chk({tag, "_rd_lat"}, n, d);
        chk({tag, "_st_strm"}, int'(state), 2);
        tick();
        chk({tag, "_dv"}, int'(dv), 1);
        repeat (3) tick();
        chk({tag, "_level"}, int'(level), d);
    endtask

    task automatic drain(input string tag, input int l);
        int n;
        en = 1'b0;
        tick();
        chk({tag, "_wr_m"}, int'(wr_en), 1);
        tick();
        chk({tag, "_wr_off"}, int'(wr_en), 0);
        chk({tag, "_st_flush"}, int'(state), 3);
        chk({tag, "_rd_flush"}, int'(rd_en), int'(l != 0));
        n = 0;
        while (rd_en && n < 2100) begin
            tick();
            n++;
        end
        chk({tag, "_rd_cnt"}, n, l);
        chk({tag, "_st_idle"}, int'(state), 0);
        chk({tag, "_lvl0"}, int'(level), 0);
        tick();
        tick();
        chk({tag, "_sb_left"}, sb_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef DELAY_FIFO_CTRL_ERR_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        rst        = 1'b1;
        en         = 1'b0;
        cfg_we     = 1'b0;
        cfg_delay  = '0;
        fifo_full  = 1'b0;
        fifo_empty = 1'b0;
        sb_on      = 1'b1;
        exp_delay  = 73;
        #1;
        chk("rst_wr", int'(wr_en), 0);
        chk("rst_rd", int'(rd_en), 0);
        chk("rst_dv", int'(dv), 0);
        chk("rst_lvl", int'(level), 0);
        chk("rst_st", int'(state), 0);
        chk("rst_ovf", int'(err_ovf), 0);
        chk("rst_udf", int'(err_udf), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("idle_st", int'(state), 0);

        start_run("dflt", 73);
        // Write while streaming must be ignored.
        set_delay(5);
        tick();
        chk("rej_lvl", int'(level), 73);
        drain("rej", 73);
        start_run("rej2", 73);
        drain("rej2", 73);

        set_delay(5);
        start_run("d5", 5);
        drain("d5", 5);

        set_delay(0);
        start_run("clamp0", 1);
        drain("clamp0", 1);

        set_delay(2000);
        start_run("clamp_hi", 1023);
        drain("clamp_hi", 1023);

        en = 1'b1;
        tick();
        tick();
        repeat (30) tick();
        chk("mid_st_fill", int'(state), 1);
        rst = 1'b1;
        sb_q.delete();
        #1;
        chk("mid_wr", int'(wr_en), 0);
        chk("mid_rd", int'(rd_en), 0);
        chk("mid_dv", int'(dv), 0);
        chk("mid_lvl", int'(level), 0);
        chk("mid_st", int'(state), 0);
        en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        start_run("post_rst", 73);

        sb_on = 1'b0;
        fifo_empty = 1'b1;
        tick();
        fifo_empty = 1'b0;
        chk("udf_set", int'(err_udf), exp_err);
        chk("udf_lvl", int'(level), 74);
        repeat (3) tick();
        chk("udf_sticky", int'(err_udf), exp_err);
        chk("ovf_clear", int'(err_ovf), 0);
        fifo_full = 1'b1;
        tick();
        fifo_full = 1'b0;
        chk("ovf_set", int'(err_ovf), exp_err);
        chk("ovf_lvl", int'(level), 73);
        rst = 1'b1;
        #1;
        chk("err_rst_udf", int'(err_udf), 0);
        chk("err_rst_ovf", int'(err_ovf), 0);
        en = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
